mult32x32_dot_seq: RTL

Sequencer that sits directly upstream and downstream of mult32x32_fast. It accepts a stream of 32-bit operand pairs over a valid/ready handshake and buffers them in a small FIFO. Each pair is issued to the multiplier with a one-cycle start pulse, and each 64-bit product is captured when the multiplier's busy falls. Products are accumulated into a dot-product sum, which is presented on a valid/ready output when the pair tagged "last" completes.

---
 rtl/mult32x32_dot_pkg.sv | 38 +++
 rtl/mult32x32_dot_fifo.sv | 91 +++++++++
 rtl/mult32x32_dot_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mult32x32_dot_pkg.sv
// ---------------------------------------------------------------------------
// mult32x32_dot_pkg
//
// Shared types and constants for the dot-product sequencer that wraps
// mult32x32_fast. The sequencer top (mult32x32_dot_seq) and its operand FIFO
// (mult32x32_dot_fifo) both import this package.
//
// Contents:
//   OP_W      - operand width fed to the multiplier (32)
//   PROD_W    - product / accumulator width (64)
//   state_t   - sequencer FSM states
//   operand_t - one buffered operand pair plus its end-of-dot-product tag
// ---------------------------------------------------------------------------
package mult32x32_dot_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;

    // Sequencer states. A term walks IDLE -> ISSUE -> WAIT_HI -> WAIT_LO and
    // either returns to IDLE for the next term or parks in OUT until the
    // finished sum has been taken by the consumer.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        OUT     = 3'd4
    } state_t;

    // One operand pair as stored in the FIFO. 'last' marks the final term
    // of the current dot product.
    typedef struct packed {
        logic            last;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } operand_t;

endpackage

// File: rtl/mult32x32_dot_fifo.sv
// ---------------------------------------------------------------------------
// mult32x32_dot_fifo
//
// Synchronous FIFO of operand_t entries used to buffer operand pairs ahead of
// the multiplier. Pointers carry one extra wrap bit so that full and empty
// can be told apart when the index bits are equal.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset (0 = FIFO emptied)
//   push      - write push_data this cycle (ignored while full)
//   push_data - operand pair to store
//   pop       - drop the head entry this cycle (ignored while empty)
//   pop_data  - current head entry (valid whenever empty = 0)
//   full      - DEPTH entries stored, registered state only
//   empty     - no entries stored, registered state only
//
// A push and a pop in the same cycle are both honoured. When the FIFO is
// full the push is refused even if a pop happens in the same cycle, which
// matches the upstream in_ready = !full handshake.
// ---------------------------------------------------------------------------
module mult32x32_dot_fifo
    import mult32x32_dot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  operand_t push_data,
    input  logic     pop,
    output operand_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    operand_t       mem_q [DEPTH];
    operand_t       mem_d [DEPTH];

    logic push_ok;
    logic pop_ok;

    // Flags come straight from the registered pointers: equal pointers mean
    // empty, equal index bits with differing wrap bits mean full.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    // Next-state for the pointers and storage. Each pointer advances only on
    // an accepted operation; the storage slot under the write pointer is
    // overwritten on an accepted push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
            wr_ptr_d                   = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // State register. Reset discards every buffered pair by collapsing the
    // pointers; storage is cleared too so the head never shows stale data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/mult32x32_dot_seq.sv
// ---------------------------------------------------------------------------
// mult32x32_dot_seq
//
// Dot-product sequencer placed around mult32x32_fast. Operand pairs arrive
// over a valid/ready handshake and are buffered in a DEPTH-entry FIFO. Each
// pair is handed to the multiplier with a one-cycle start pulse, and its
// 64-bit product is added to a running sum when the multiplier's busy
// falls. When the pair tagged 'last' completes, the sum and the number of
// terms are offered on a valid/ready output and held until taken.
//
// Ports:
//   clk, reset             - rising-edge clock, async active-low reset
//   in_valid/in_ready      - operand pair handshake (in_ready = !full)
//   in_a, in_b, in_last    - unsigned operands and end-of-sum tag
//   mul_start              - one-cycle start pulse to the multiplier
//   mul_a, mul_b           - operands to the multiplier, held from issue
//                            until the next pop
//   mul_busy, mul_product  - multiplier status and 64-bit result
//   out_valid/out_ready    - finished-sum handshake
//   out_sum                - accumulated sum, modulo 2^64
//   out_count              - number of terms in the sum, saturating
// ---------------------------------------------------------------------------
module mult32x32_dot_seq
    import mult32x32_dot_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic              in_last,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic              mul_busy,
    input  logic [PROD_W-1:0] mul_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_sum,
    output logic [CNT_W-1:0]  out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t              state_q, state_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [OP_W-1:0]     mul_a_q, mul_a_d;
    logic [OP_W-1:0]     mul_b_q, mul_b_d;
    logic                last_q, last_d;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    operand_t            fifo_in;
    operand_t            fifo_head;

    // Upstream handshake. in_ready depends only on the registered FIFO
    // pointers, so a pop in the same cycle never opens a slot early.
    always_comb begin
        in_ready     = !fifo_full;
        fifo_push    = in_valid && in_ready;
        fifo_in.last = in_last;
        fifo_in.a    = in_a;
        fifo_in.b    = in_b;
    end

    mult32x32_dot_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sequencer next-state and outputs.
    //  - IDLE latches the FIFO head into the operand registers as it pops.
    //  - ISSUE is the only state that raises mul_start, giving one pulse.
    //  - WAIT_HI waits for the multiplier to acknowledge with busy so that
    //    the still-low busy from before the start is not taken as done.
    //  - WAIT_LO captures the product on the first cycle busy is low again.
    //  - OUT holds the sum until the consumer takes it; the FIFO keeps
    //    filling meanwhile but nothing new is issued.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        last_d    = last_q;
        fifo_pop  = 1'b0;
        mul_start = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    mul_a_d  = fifo_head.a;
                    mul_b_d  = fifo_head.b;
                    last_d   = fifo_head.last;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_d   = WAIT_HI;
            end
            WAIT_HI: begin
                if (mul_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!mul_busy) begin
                    acc_d = acc_q + mul_product;
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_ONE;
                    end
                    state_d = last_q ? OUT : IDLE;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The sum and count are presented straight from their registers, which
    // only change in WAIT_LO or on the OUT handshake, so they stay stable
    // while out_valid waits for out_ready.
    always_comb begin
        mul_a     = mul_a_q;
        mul_b     = mul_b_q;
        out_sum   = acc_q;
        out_count = count_q;
    end

    // State register. Reset throws away any partial sum; the multiplier is
    // reset by the same signal so no stale busy can arrive afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            last_q  <= last_d;
        end
    end

endmodule
